// File: rtl/logic_op_pipe.sv
// Two-stage registered AND/OR/XOR/NOT unit with a zero flag and a consumed-result counter.
// Latency 2 edges from acceptance; out_ready stalls S2 then S1, and in_ready falls only when both are full.
module logic_op_pipe #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_zero,
    output logic [1:0]           out_op,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic             s1_valid;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       op1;
    logic             s2_valid;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] f;

    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = !s1_valid || s2_free;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    always_comb begin
        f = '0;
        case (op1)
            OP_AND:  f = a1 & b1;
            OP_OR:   f = a1 | b1;
            OP_XOR:  f = a1 ^ b1;
            default: f = ~a1;
        endcase
    end

    // Operand registers carry no meaning while s1_valid is low, so they skip reset.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            a1  <= in_a;
            b1  <= in_b;
            op1 <= in_op;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_op     <= 2'b00;
            op_count   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                out_result <= f;
                out_zero   <= (f == '0);
                out_op     <= op1;
                s2_valid   <= 1'b1;
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end

            if (out_fire) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: drives on the falling edge and samples before the next rising edge.
module tb_logic_op_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [1:0]  out_op;
    logic [3:0]  op_count;

    int n_cmp;
    int n_err;

    logic_op_pipe #(.WIDTH(32), .CNT_WIDTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_op     (out_op),
        .op_count   (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic zero, input logic [1:0] op);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, out_result, res);
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, zero});
        check({tag, "_op"}, {30'd0, out_op}, {30'd0, op});
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        @(negedge clock);
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_op_count", {28'd0, op_count}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_zero", {31'd0, out_zero}, 32'd0);

        // First transaction: zero AND zero, two-edge latency.
        out_ready = 1'b1;
        drive(2'b00, 32'h0000_0000, 32'h0000_0000);
        tick();
        in_valid = 1'b0;
        check("t1_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        expect_out("t1", 32'h0000_0000, 1'b1, 2'b00);
        tick();
        check("t1_drained", {31'd0, out_valid}, 32'd0);
        check("t1_count", {28'd0, op_count}, 32'd1);

        // Back-to-back AND.
        drive(2'b00, 32'h0000_FF00, 32'h0000_FF00);
        tick();
        drive(2'b00, 32'h1111_1111, 32'h1111_1111);
        tick();
        expect_out("and1", 32'h0000_FF00, 1'b0, 2'b00);
        drive(2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F);
        tick();
        expect_out("and2", 32'h1111_1111, 1'b0, 2'b00);
        in_valid = 1'b0;
        tick();
        expect_out("and3", 32'h0F0F_0000, 1'b0, 2'b00);
        tick();
        check("and_drained", {31'd0, out_valid}, 32'd0);
        check("and_count", {28'd0, op_count}, 32'd4);

        // OR / XOR / NOT A (b deliberately nonzero for NOT).
        drive(2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick();
        drive(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick();
        expect_out("or", 32'hFFF0_FFF0, 1'b0, 2'b01);
        drive(2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick();
        expect_out("xor", 32'h0FF0_0FF0, 1'b0, 2'b10);
        in_valid = 1'b0;
        tick();
        expect_out("not", 32'h0F0F_0F0F, 1'b0, 2'b11);
        tick();
        check("ops_count", {28'd0, op_count}, 32'd7);

        // Stall: S2 then S1 fill, third request waits.
        out_ready = 1'b0;
        drive(2'b00, 32'h1234_5678, 32'hFFFF_FFFF);
        #1;
        check("stall_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        drive(2'b01, 32'h0000_0000, 32'hA5A5_A5A5);
        #1;
        check("stall_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        drive(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        check("stall_rdy_full", {31'd0, in_ready}, 32'd0);
        tick();
        check("stall_rdy_hold", {31'd0, in_ready}, 32'd0);
        expect_out("stall_head", 32'h1234_5678, 1'b0, 2'b00);
        out_ready = 1'b1;
        #1;
        check("stall_rdy_comb", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        expect_out("stall_x2", 32'hA5A5_A5A5, 1'b0, 2'b01);
        tick();
        expect_out("stall_x3", 32'h0000_0000, 1'b1, 2'b10);
        tick();
        check("stall_drained", {31'd0, out_valid}, 32'd0);
        check("stall_count", {28'd0, op_count}, 32'd10);

        // Full pipe consumes and accepts in the same edge, no bubble.
        out_ready = 1'b0;
        drive(2'b11, ~32'd1, 32'd0);
        tick();
        drive(2'b11, ~32'd2, 32'd0);
        tick();
        drive(2'b11, ~32'd3, 32'd0);
        out_ready = 1'b1;
        #1;
        check("full_rdy_a", {31'd0, in_ready}, 32'd1);
        tick();
        expect_out("full_y2", 32'd2, 1'b0, 2'b11);
        check("full_rdy_b", {31'd0, in_ready}, 32'd1);
        drive(2'b11, ~32'd4, 32'd0);
        tick();
        expect_out("full_y3", 32'd3, 1'b0, 2'b11);
        in_valid = 1'b0;
        tick();
        expect_out("full_y4", 32'd4, 1'b0, 2'b11);
        tick();
        check("full_count", {28'd0, op_count}, 32'd14);

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        drive(2'b01, 32'hDEAD_BEEF, 32'h0);
        tick();
        drive(2'b01, 32'hCAFE_F00D, 32'h0);
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_count", {28'd0, op_count}, 32'd0);
        tick();
        check("mrst_ghost1", {31'd0, out_valid}, 32'd0);
        tick();
        check("mrst_ghost2", {31'd0, out_valid}, 32'd0);
        check("mrst_count2", {28'd0, op_count}, 32'd0);

        // Counter wrap: 17 consumed results with a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            drive(2'b00, i, 32'hFFFF_FFFF);
            tick();
            if (i == 5) check("wrap_mid_result", out_result, 32'd4);
        end
        in_valid = 1'b0;
        tick();
        check("wrap_last_result", out_result, 32'd16);
        tick();
        check("wrap_count", {28'd0, op_count}, 32'd1);
        check("wrap_drained", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
Two-stage registered bitwise-logic unit with valid/ready handshakes on both sides. It sits directly upstream of the ALU result mux: it accepts operand pairs plus a logic opcode, registers the operands (S1), and evaluates AND/OR/XOR/NOT of A using the team's and_32/or_32-style 32-bit gates. It registers the result with a zero flag (S2) and keeps a completed-operation counter. It lets the 32-bit logic path be pipelined and stalled independently of the adder path.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_WIDTH, 16, width of completed-operation counter

Ports:
clock  input  1  single system clock, all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
in_valid  input  1  upstream presents a request
in_ready  output  1  block accepts request this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  2  00=AND, 01=OR, 10=XOR, 11=NOT A (in_b ignored)
out_valid  output  1  S2 holds a result
out_ready  input  1  downstream consumes result this cycle
out_result  output  WIDTH  registered logic result
out_zero  output  1  1 when out_result == 0
out_op  output  2  opcode that produced out_result
op_count  output  CNT_WIDTH  number of results consumed (out_valid && out_ready) since reset

Behaviour:
- Reset (reset=1 at posedge) clears s1_valid, s2_valid, out_result, out_zero, out_op and op_count to 0, and discards any in-flight request. Reset takes priority over every handshake in the same cycle. in_ready reads 1 in the first cycle after reset is released.
- Handshakes:
  - Input transfer: in_valid && in_ready at posedge.
  - Output transfer: out_valid && out_ready at posedge.
  - in_valid does not depend on in_ready; out_valid does not depend on out_ready.
- Stage advance:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready; no other combinational path from inputs to outputs.
- S1 (operand register):
  - On input transfer, load a1/b1/op1 and set s1_valid=1.
  - Else if s1_adv, clear s1_valid.
  - Else hold all fields.
- S2 (result register):
  - On s1_adv, load out_result = f(op1, a1, b1), out_zero = (f == 0), out_op = op1, and set s2_valid=1.
  - Else if output transfer, clear s2_valid (data fields may hold stale values).
  - Else hold.
- Latency and throughput:
  - Request accepted at edge N appears with out_valid=1 after edge N+1 when unstalled, i.e. 2 registers.
  - Sustained throughput is 1 result/cycle when out_ready stays 1.
- Backpressure:
  - With out_ready=0, S2 then S1 fill; in_ready drops to 0 once both are full.
  - No request is lost or duplicated. Results exit in acceptance order.
- Simultaneous events: with both stages full, out_ready=1 and in_valid=1 in the same cycle, S2 takes S1 and S1 takes the new request in the same edge (no bubble).
- op_count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Operations are purely bitwise with no carry or overflow; WIDTH bits in, WIDTH bits out.
- Outputs while out_valid=0 carry no meaning except op_count.

Test Plan:
- Reset then in_op=00, a=b=32'h00000000, out_ready=1 -> 2 edges later out_valid=1, out_result=00000000, out_zero=1, op_count=1 after consumption.
- Back-to-back AND: a=b=32'h0000FF00, then a=b=32'h11111111, then a=FFFF0000/b=0F0F0F0F -> results 0000FF00, 11111111, 0F0F0000 on consecutive cycles, out_zero=0 each.
- Op coverage: a=F0F0F0F0, b=FF00FF00 for ops 01/10/11 -> FFF0FFF0, 0FF00FF0, 0F0F0F0F; out_op echoes 01/10/11.
- Stall: out_ready=0 with 3 requests offered -> in_ready falls to 0 after 2 accepted. Raise out_ready -> 3 results out in order, none lost, op_count=3.
- Simultaneous full-pipe consume and accept: in_ready stays 1, no bubble between results.
- Reset mid-flight with both stages full -> next cycle out_valid=0, in_ready=1, op_count=0. The old request never appears.
- Counter wrap (CNT_WIDTH=4): 17 consumed results -> op_count=1.
